// File: rtl/math_pkg.sv
// Shared types and constants for the arithmetic quiz controller.
package math_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ASK,
    S_JUDGE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  localparam logic [2:0] MAX_OPERAND = 3'd5;
  localparam int         ANS_W       = 5;

endpackage

// File: rtl/math_quiz_ctrl_timer.sv
// Per-question countdown: loadable, counts down while enabled, holds at zero.
module round_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/math_quiz_ctrl.sv
// Quiz game controller: presents ROUNDS arithmetic questions, times each answer,
// and keeps a saturating score.
module math_quiz_ctrl
  import math_pkg::*;
#(
  parameter int ROUNDS     = 8,
  parameter int TIME_LIMIT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] num_a,
  input  logic [2:0] num_b,
  input  logic       start,
  input  logic       ans_valid,
  input  logic [4:0] ans,
  output logic [2:0] opnd_a,
  output logic [2:0] opnd_b,
  output logic [1:0] op,
  output logic       q_valid,
  output logic       correct,
  output logic       wrong,
  output logic       timeout,
  output logic [3:0] score,
  output logic       done
);

  localparam int TW = (TIME_LIMIT > 2) ? $clog2(TIME_LIMIT) : 1;

  state_e           state_q;
  logic [3:0]       round_q;
  logic [3:0]       score_q;
  logic [2:0]       opnd_a_q, opnd_b_q;
  op_e              op_q;
  logic [ANS_W-1:0] exp_q;
  logic [ANS_W-1:0] ans_q;
  logic             to_q;
  logic             q_valid_q, correct_q, wrong_q, timeout_q, done_q;

  logic [2:0]       ca, cb;
  logic [3:0]       rmod;
  op_e              op_d;
  logic [2:0]       opnd_a_d, opnd_b_d;
  logic [ANS_W-1:0] exp_d;
  logic             tmr_zero;

  always_comb begin
    ca       = (num_a > MAX_OPERAND) ? MAX_OPERAND : num_a;
    cb       = (num_b > MAX_OPERAND) ? MAX_OPERAND : num_b;
    rmod     = round_q % 4'd3;
    op_d     = op_e'(rmod[1:0]);
    opnd_a_d = ca;
    opnd_b_d = cb;
    // Subtraction puts the larger operand first so the result is never negative.
    if (op_d == OP_SUB && cb > ca) begin
      opnd_a_d = cb;
      opnd_b_d = ca;
    end
    case (op_d)
      OP_SUB:  exp_d = ANS_W'(opnd_a_d) - ANS_W'(opnd_b_d);
      OP_MUL:  exp_d = ANS_W'(opnd_a_d) * ANS_W'(opnd_b_d);
      default: exp_d = ANS_W'(opnd_a_d) + ANS_W'(opnd_b_d);
    endcase
  end

  round_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == S_LOAD),
    .load_val_i (TW'(TIME_LIMIT - 1)),
    .en_i       (state_q == S_ASK),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      score_q   <= '0;
      opnd_a_q  <= '0;
      opnd_b_q  <= '0;
      op_q      <= OP_ADD;
      exp_q     <= '0;
      ans_q     <= '0;
      to_q      <= 1'b0;
      q_valid_q <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_LOAD;
            score_q <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          opnd_a_q  <= opnd_a_d;
          opnd_b_q  <= opnd_b_d;
          op_q      <= op_d;
          exp_q     <= exp_d;
          to_q      <= 1'b0;
          q_valid_q <= 1'b1;
          state_q   <= S_ASK;
        end
        S_ASK: begin
          // An answer on the timer-zero cycle takes priority over the timeout.
          if (ans_valid) begin
            ans_q     <= ans;
            q_valid_q <= 1'b0;
            state_q   <= S_JUDGE;
          end else if (tmr_zero) begin
            timeout_q <= 1'b1;
            to_q      <= 1'b1;
            q_valid_q <= 1'b0;
            state_q   <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          if (!to_q) begin
            if (ans_q == exp_q) begin
              correct_q <= 1'b1;
              if (score_q != '1) score_q <= score_q + 4'd1;
            end else begin
              wrong_q <= 1'b1;
            end
          end
          round_q <= round_q + 4'd1;
          if (round_q == 4'(ROUNDS - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign opnd_a  = opnd_a_q;
  assign opnd_b  = opnd_b_q;
  assign op      = op_q;
  assign q_valid = q_valid_q;
  assign correct = correct_q;
  assign wrong   = wrong_q;
  assign timeout = timeout_q;
  assign score   = score_q;
  assign done    = done_q;

endmodule

// File: tb/tb_math_quiz_ctrl.sv
// Self-checking bench for math_quiz_ctrl: directed games plus randomized games
// checked against an arithmetic reference model of the quiz rules.
module tb_math_quiz_ctrl;

  localparam int ROUNDS = 3;
  localparam int TL     = 4;

  logic       clk = 1'b0;
  logic       rst, start, ans_valid;
  logic [2:0] num_a, num_b;
  logic [4:0] ans;
  logic [2:0] opnd_a, opnd_b;
  logic [1:0] op;
  logic       q_valid, correct, wrong, timeout, done;
  logic [3:0] score;

  int compared   = 0;
  int mismatched = 0;
  int round_m    = 0;
  int score_m    = 0;

  math_quiz_ctrl #(.ROUNDS(ROUNDS), .TIME_LIMIT(TL)) dut (
    .clk       (clk),
    .rst       (rst),
    .num_a     (num_a),
    .num_b     (num_b),
    .start     (start),
    .ans_valid (ans_valid),
    .ans       (ans),
    .opnd_a    (opnd_a),
    .opnd_b    (opnd_b),
    .op        (op),
    .q_valid   (q_valid),
    .correct   (correct),
    .wrong     (wrong),
    .timeout   (timeout),
    .score     (score),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".q_valid"}, 8'(q_valid), 8'd0);
    chk({tag, ".correct"}, 8'(correct), 8'd0);
    chk({tag, ".wrong"},   8'(wrong),   8'd0);
    chk({tag, ".timeout"}, 8'(timeout), 8'd0);
    chk({tag, ".done"},    8'(done),    8'd0);
    chk({tag, ".score"},   8'(score),   8'd0);
    chk({tag, ".opnd_a"},  8'(opnd_a),  8'd0);
    chk({tag, ".opnd_b"},  8'(opnd_b),  8'd0);
    chk({tag, ".op"},      8'(op),      8'd0);
  endtask

  function automatic int clamp5(input int v);
    return (v > 5) ? 5 : v;
  endfunction

  function automatic logic [4:0] ref_answer(input int a, input int b, input int r);
    int x, y, res;
    x = clamp5(a);
    y = clamp5(b);
    case (r % 3)
      0:       res = x + y;
      1:       res = (x > y) ? x - y : y - x;
      default: res = x * y;
    endcase
    return 5'(res);
  endfunction

  task automatic start_game(input logic [2:0] a, input logic [2:0] b);
    num_a = a;
    num_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    round_m = 0;
    score_m = 0;
    chk("start.score_clear", 8'(score), 8'd0);
    chk("start.done_clear",  8'(done),  8'd0);
  endtask

  // One question: answer after `delay` cycles of q_valid, or let it time out
  // when delay >= TL. Operands for the following question are applied during JUDGE.
  task automatic question(input logic [2:0] a, input logic [2:0] b, input int delay,
                          input logic [4:0] av, input logic [2:0] na, input logic [2:0] nb);
    int         n, x, y;
    logic [4:0] e;
    bit         hit, last;
    x    = clamp5(int'(a));
    y    = clamp5(int'(b));
    if ((round_m % 3) == 1 && y > x) begin
      n = x; x = y; y = n;
    end
    e    = ref_answer(int'(a), int'(b), round_m);
    last = (round_m == ROUNDS - 1);
    n = 0;
    while (q_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("q.q_valid_rise", 8'(q_valid), 8'd1);
    chk("q.opnd_a", 8'(opnd_a), 8'(x));
    chk("q.opnd_b", 8'(opnd_b), 8'(y));
    chk("q.op",     8'(op),     8'(round_m % 3));
    if (delay >= TL) begin
      for (int i = 1; i < TL; i++) begin
        @(negedge clk);
        chk("q.no_early_timeout", 8'(timeout), 8'd0);
      end
      @(negedge clk);
      chk("q.timeout_pulse", 8'(timeout), 8'd1);
      chk("q.q_valid_drop",  8'(q_valid), 8'd0);
      num_a = na;
      num_b = nb;
      @(negedge clk);
      chk("q.to_no_correct", 8'(correct), 8'd0);
      chk("q.to_no_wrong",   8'(wrong),   8'd0);
      chk("q.to_once",       8'(timeout), 8'd0);
    end else begin
      repeat (delay) @(negedge clk);
      ans_valid = 1'b1;
      ans       = av;
      @(negedge clk);
      ans_valid = 1'b0;
      chk("q.q_valid_drop", 8'(q_valid), 8'd0);
      chk("q.no_timeout",   8'(timeout), 8'd0);
      num_a = na;
      num_b = nb;
      hit = (av == e);
      if (hit && score_m < 15) score_m++;
      @(negedge clk);
      chk("q.correct", 8'(correct), 8'(hit));
      chk("q.wrong",   8'(wrong),   8'(!hit));
    end
    chk("q.score", 8'(score), 8'(score_m));
    chk("q.done",  8'(done),  8'(last));
    round_m++;
    @(negedge clk);
    chk("q.pulse_end_c", 8'(correct), 8'd0);
    chk("q.pulse_end_w", 8'(wrong),   8'd0);
  endtask

  initial begin
    logic [2:0] a, b, na, nb;
    logic [4:0] e, av;
    int         n;

    rst = 1'b1; start = 1'b0; ans_valid = 1'b0; ans = '0; num_a = '0; num_b = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle.no_q", 8'(q_valid), 8'd0);

    // Game 1: correct, wrong (sub swaps operands), timeout
    start_game(3'd3, 3'd4);
    question(3'd3, 3'd4, 0, 5'd7, 3'd2, 3'd5);
    question(3'd2, 3'd5, 1, 5'd4, 3'd5, 3'd5);
    question(3'd5, 3'd5, TL, 5'd0, 3'd7, 3'd1);
    ans_valid = 1'b1;
    ans       = 5'd25;
    @(negedge clk);
    ans_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("done.hold",       8'(done),    8'd1);
    chk("done.score",      8'(score),   8'd1);
    chk("done.ignore_ans", 8'(correct), 8'd0);
    chk("done.opnd_a",     8'(opnd_a),  8'd5);
    chk("done.opnd_b",     8'(opnd_b),  8'd5);
    chk("done.op",         8'(op),      8'd2);

    // Game 2: clamp, answer on timer-zero cycle, all correct
    start_game(3'd7, 3'd1);
    question(3'd7, 3'd1, TL - 1, 5'd6, 3'd3, 3'd3);
    question(3'd3, 3'd3, 2, 5'd0, 3'd4, 3'd2);
    question(3'd4, 3'd2, 0, 5'd8, 3'd0, 3'd0);
    @(negedge clk);
    chk("game2.done",  8'(done),  8'd1);
    chk("game2.score", 8'(score), 8'd3);

    // Randomized games
    for (int g = 0; g < 4; g++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      start_game(a, b);
      for (int r = 0; r < ROUNDS; r++) begin
        na = 3'($urandom_range(0, 7));
        nb = 3'($urandom_range(0, 7));
        e  = ref_answer(int'(a), int'(b), round_m);
        av = ($urandom_range(0, 1) == 1) ? e : 5'($urandom_range(0, 31));
        question(a, b, int'($urandom_range(0, TL)), av, na, nb);
        a = na;
        b = nb;
      end
    end

    // Reset in the middle of a question
    start_game(3'd1, 3'd2);
    n = 0;
    while (q_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst.q_valid", 8'(q_valid), 8'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    ans_valid = 1'b1;
    ans       = 5'd3;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rel.correct", 8'(correct), 8'd0);
      chk("rel.wrong",   8'(wrong),   8'd0);
      chk("rel.q_valid", 8'(q_valid), 8'd0);
    end
    ans_valid = 1'b0;
    start_game(3'd2, 3'd3);
    question(3'd2, 3'd3, 0, 5'd5, 3'd1, 3'd1);
    chk("restart.score", 8'(score), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/math_quiz_ctrl.md
MATH_QUIZ_CTRL -- requirements
Module: math_quiz_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 8, questions per game (1..15).
REQ-002 SHALL have parameter TIME_LIMIT, default 1000, clock cycles allowed per answer (>=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port num_a, input, 3, random operand source A (random-number stage, nominal 0..5).
REQ-006 SHALL have port num_b, input, 3, random operand source B (nominal 0..5).
REQ-007 SHALL have port start, input, 1, level; begins a game when sampled high in IDLE or DONE.
REQ-008 SHALL have ports ans_valid (input, 1, player answer strobe) and ans (input, 5, unsigned player answer).
REQ-009 SHALL have ports opnd_a, opnd_b (output, 3 each, displayed operands) and op (output, 2: 0=add, 1=sub, 2=mul).
REQ-010 SHALL have port q_valid, output, 1, high while a question awaits an answer.
REQ-011 SHALL have ports correct, wrong, timeout (output, 1 each, single-cycle result pulses).
REQ-012 SHALL have ports score (output, 4, correct count this game) and done (output, 1, game over).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, ASK, JUDGE, DONE.
REQ-014 IDLE/DONE + start=1 SHALL go to LOAD, clearing score and round counter; start elsewhere ignored.
REQ-015 LOAD (one cycle) SHALL sample num_a/num_b, clamp values >5 to 5, latch into opnd_a/opnd_b.
REQ-016 op SHALL be round index mod 3 (round 0 add, 1 sub, 2 mul, 3 add, ...).
REQ-017 For sub, opnd_a SHALL hold the larger and opnd_b the smaller operand, so result >=0.
REQ-018 Expected answer SHALL be computed in LOAD, registered at 5 bits (max 25), not exposed.
REQ-019 LOAD SHALL go to ASK, asserting q_valid and loading the timer with TIME_LIMIT-1.
REQ-020 ASK SHALL decrement timer each cycle; ans_valid=1 latches ans and goes to JUDGE.
REQ-021 Timer at 0 with ans_valid=0 SHALL pulse timeout one cycle, count as wrong-free miss, go to JUDGE.
REQ-022 ans_valid coincident with timer 0 SHALL be treated as an answer (answer wins over timeout).
REQ-023 JUDGE (one cycle) SHALL pulse correct if ans==expected else wrong (no pulse after timeout); score++ on correct.
REQ-024 q_valid SHALL deassert on the cycle JUDGE is entered; ans_valid outside ASK ignored.
REQ-025 JUDGE SHALL increment round; if round was ROUNDS-1 go to DONE, else LOAD.
REQ-026 DONE SHALL hold done=1, score, last operands stable until start.
REQ-027 Score SHALL saturate at 15 (never wraps).

Reset
REQ-028 rst SHALL immediately force IDLE, timer 0, round 0, score 0, opnd_a/opnd_b/op 0, all pulses/q_valid/done 0.
REQ-029 rst mid-game SHALL abandon the game; no result pulse emitted on the reset release edge.

Structure
REQ-030 Shared package math_pkg SHALL hold the state enum, op enum (OP_ADD/OP_SUB/OP_MUL), MAX_OPERAND=5, ANS_W=5.
REQ-031 Per-question countdown SHALL be sub-module round_timer (load, enable, zero flag).
REQ-032 Operand clamping and answer arithmetic SHALL stay inside math_quiz_ctrl.

Verification
REQ-033 Reset, start pulse, num_a=3, num_b=4, round 0 -> op=0, q_valid; ans=7 -> one-cycle correct, score=1.
REQ-034 Round 1, num_a=2, num_b=5 -> opnd_a=5, opnd_b=2, op=1; ans=4 -> wrong pulse, score unchanged.
REQ-035 Round 2, num_a=5, num_b=5, no answer, TIME_LIMIT=4 -> timeout pulse exactly 4 cycles after q_valid rise, no wrong pulse.
REQ-036 num_a=7 (out of range) -> opnd_a=5; ans_valid on timer-zero cycle with correct ans -> correct, no timeout.
REQ-037 ROUNDS=3 all correct -> done=1, score=3, start in DONE -> score=0, new LOAD.
REQ-038 rst asserted during ASK -> outputs zero asynchronously, IDLE; start then restarts at round 0.
